// File: rtl/axis_uart_byte_packer.sv
// Packs the UART receiver's AXI-Stream byte stream into little-endian N_BYTES-wide words.
// A partial word left idle for the inter-byte timeout is discarded and counted.
module axis_uart_byte_packer #(
   parameter int UART_SPEED    = 115200,
   parameter int FREQ_HZ       = 100000000,
   parameter int N_BYTES       = 32,
   parameter int TIMEOUT_CHARS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             S_AXIS_TDATA,
   input  logic                   S_AXIS_TVALID,
   output logic                   S_AXIS_TREADY,
   output logic [N_BYTES*8-1:0]   M_AXIS_TDATA,
   output logic                   M_AXIS_TVALID,
   input  logic                   M_AXIS_TREADY,
   output logic                   TIMEOUT_EVENT,
   output logic [15:0]            DROP_COUNT
);

   localparam int TMO_RAW = (FREQ_HZ / UART_SPEED) * 10 * TIMEOUT_CHARS;
   // Floor of 2 keeps the counter at least one bit wide for degenerate configurations.
   localparam int TMO     = (TMO_RAW < 2) ? 2 : TMO_RAW;
   localparam int TW      = $clog2(TMO);
   localparam int IW      = $clog2(N_BYTES);
   localparam int DW      = N_BYTES * 8;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

   logic [DW-1:0] acc_r;
   logic [DW-1:0] acc_s;
   logic [DW-1:0] lane_s;
   logic [IW-1:0] idx_r;
   logic [IW-1:0] idx_s;
   logic          pend_r;
   logic          pend_s;
   logic [TW-1:0] tmo_r;
   logic [TW-1:0] tmo_s;
   logic          rdy_r;
   logic [DW-1:0] out_data_r;
   logic [DW-1:0] out_data_s;
   logic          out_valid_r;
   logic          out_valid_s;
   logic          evt_r;
   logic          evt_s;
   logic [15:0]   drop_r;
   logic [15:0]   drop_s;
   logic          accept_s;
   logic          slot_free_s;

   assign accept_s    = S_AXIS_TVALID && rdy_r;
   assign slot_free_s = !out_valid_r || M_AXIS_TREADY;

   // Accumulator image with the incoming byte dropped into the current lane.
   always_comb begin
      lane_s = acc_r;
      lane_s[{idx_r, 3'b000} +: 8] = S_AXIS_TDATA;
   end

   // Next-state for accumulator, output slot, pending word and timeout.
   always_comb begin
      acc_s       = acc_r;
      idx_s       = idx_r;
      pend_s      = pend_r;
      tmo_s       = tmo_r;
      out_data_s  = out_data_r;
      out_valid_s = out_valid_r && !M_AXIS_TREADY;
      evt_s       = 1'b0;
      drop_s      = drop_r;
      if (pend_r) begin
         tmo_s = '0;
         if (slot_free_s) begin
            out_data_s  = acc_r;
            out_valid_s = 1'b1;
            acc_s       = '0;
            idx_s       = '0;
            pend_s      = 1'b0;
         end else begin
            out_valid_s = 1'b1;
         end
      end else if (accept_s) begin
         tmo_s = '0;
         if (idx_r == LAST_IDX) begin
            if (slot_free_s) begin
               out_data_s  = lane_s;
               out_valid_s = 1'b1;
               acc_s       = '0;
               idx_s       = '0;
            end else begin
               acc_s  = lane_s;
               pend_s = 1'b1;
            end
         end else begin
            acc_s = lane_s;
            idx_s = idx_r + IW'(1);
         end
      end else if (idx_r != '0) begin
         if (tmo_r == TMO_LAST) begin
            acc_s = '0;
            idx_s = '0;
            tmo_s = '0;
            evt_s = 1'b1;
            if (drop_r != 16'hFFFF) begin
               drop_s = drop_r + 16'd1;
            end else begin
               drop_s = drop_r;
            end
         end else begin
            tmo_s = tmo_r + TW'(1);
         end
      end else begin
         tmo_s = '0;
      end
   end

   // State registers; every output comes straight from a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_r       <= '0;
         idx_r       <= '0;
         pend_r      <= 1'b0;
         tmo_r       <= '0;
         rdy_r       <= 1'b0;
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         evt_r       <= 1'b0;
         drop_r      <= 16'd0;
      end else begin
         acc_r       <= acc_s;
         idx_r       <= idx_s;
         pend_r      <= pend_s;
         tmo_r       <= tmo_s;
         rdy_r       <= !pend_s;
         out_data_r  <= out_data_s;
         out_valid_r <= out_valid_s;
         evt_r       <= evt_s;
         drop_r      <= drop_s;
      end
   end

   assign S_AXIS_TREADY = rdy_r;
   assign M_AXIS_TDATA  = out_data_r;
   assign M_AXIS_TVALID = out_valid_r;
   assign TIMEOUT_EVENT = evt_r;
   assign DROP_COUNT    = drop_r;

endmodule

// File: doc/axis_uart_byte_packer.md
Name: axis_uart_byte_packer

Overview:
- Assembles the 8-bit AXI-Stream byte stream from the UART receiver core into N_BYTES-wide words.
- Sits directly upstream of the word-level output of the UART bridge receive path.
- Includes an inter-byte timeout. A partial word that stalls is discarded, so a lost byte cannot misalign every following word.
- Byte order is little-endian: the first byte received lands in bits [7:0].

Parameters:
- UART_SPEED, 115200, line baud rate; used only to size the timeout.
- FREQ_HZ, 100000000, clk frequency in Hz.
- N_BYTES, 32, bytes per output word; must be >= 2.
- TIMEOUT_CHARS, 4, idle time, in character times, after which a partial word is dropped.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- S_AXIS_TDATA  in  8  received byte.
- S_AXIS_TVALID  in  1  byte valid.
- S_AXIS_TREADY  out  1  byte accepted when high together with TVALID.
- M_AXIS_TDATA  out  N_BYTES*8  assembled word.
- M_AXIS_TVALID  out  1  word valid.
- M_AXIS_TREADY  in  1  downstream ready.
- TIMEOUT_EVENT  out  1  one-cycle pulse when a partial word is discarded.
- DROP_COUNT  out  16  number of discarded partial words; saturates at 0xFFFF.

Behaviour:
- Timeout length: TMO = (FREQ_HZ/UART_SPEED)*10*TIMEOUT_CHARS cycles, integer division, computed at elaboration. The timeout counter is wide enough for TMO.
- Reset (asynchronous assert, synchronous release). All of the following clear to zero:
  - S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, TIMEOUT_EVENT, DROP_COUNT
  - accumulator, byte index, timeout counter, pending flag
- S_AXIS_TREADY goes to 1 on the first cycle after reset release.
- Reset asserted mid-word or mid-output discards everything. No event pulse, no count.
- Storage:
  - accumulator register (N_BYTES*8), byte index idx (0..N_BYTES-1), pending flag
  - output register driving M_AXIS_*
- Output slot free = !M_AXIS_TVALID || M_AXIS_TREADY.
- Byte accept (S_AXIS_TVALID && S_AXIS_TREADY):
  - Byte is written to lane idx. Timeout counter clears.
  - If idx < N_BYTES-1: idx increments.
  - If idx == N_BYTES-1 and the output slot is free: the full word, including this byte, loads the output register. M_AXIS_TVALID = 1 on the next cycle (latency 1 from last byte). Accumulator clears and idx returns to 0.
  - If idx == N_BYTES-1 and the slot is busy: the word stays in the accumulator, pending = 1, S_AXIS_TREADY = 0.
- Pending: on the first cycle the slot is free, the accumulator moves to the output register. pending clears, idx = 0, and S_AXIS_TREADY returns to 1 on the next cycle.
- S_AXIS_TREADY = !pending, registered. No combinational path from M_AXIS_TREADY to S_AXIS_TREADY.
- Simultaneous downstream handshake and word completion in the same cycle: the new word loads and TVALID stays high. No bubble, no loss.
- M_AXIS_TDATA is stable while TVALID && !TREADY.
- Timeout:
  - Counter increments each cycle while idx > 0, pending = 0, and no byte is accepted.
  - On reaching TMO-1: accumulator clears, idx = 0, counter = 0, TIMEOUT_EVENT = 1 for exactly one cycle, DROP_COUNT increments (saturating).
  - A byte accepted on the same cycle as expiry wins: the byte is stored and no timeout fires.
  - While idx == 0 or pending = 1, the counter is held at 0.
- Unused lanes are never visible, because only complete words are emitted.

Test Plan:
- Bench config: N_BYTES=4, FREQ_HZ=1000000, UART_SPEED=100000, TIMEOUT_CHARS=2, giving TMO=200.
- Bytes 0x11,0x22,0x33,0x44 back-to-back, M_AXIS_TREADY=1 -> M_AXIS_TDATA=0x44332211 with TVALID high for 1 cycle, 1 cycle after 0x44 is accepted.
- 8 bytes 0x01..0x08, M_AXIS_TREADY=0 until cycle 20 -> first word 0x04030201 held stable; S_AXIS_TREADY=0 after 0x08; after TREADY rises, 0x08070605 follows on the next cycle; no bytes lost.
- 3 bytes, then 250 idle cycles, then 0xA1..0xA4 -> TIMEOUT_EVENT pulses once, 200 cycles after the 3rd byte; DROP_COUNT=1; next word = 0xA4A3A2A1.
- Byte gap of exactly 199 idle cycles inside a word -> no timeout; word emitted intact.
- reset pulled low after 2 bytes of a word and after TVALID is asserted -> all outputs 0 immediately; the following 4 bytes form a clean word; DROP_COUNT stays 0.
- Continuous stream of 1000 random bytes, random M_AXIS_TREADY at 50% -> scoreboard matches all 250 words in order; DROP_COUNT=0.
